// File: rtl/sm5_lcd_scan.sv
// sm5_lcd_scan: LCD common/segment scanner with double-buffered display RAM snapshot.
// Define SM5_LCD_BLINK_EN to gate the Bs segment with y_reg/blink.
module sm5_lcd_scan #(
   parameter int COMMONS = 4,
   parameter int SEGS = 32,
   parameter int RAM_AW = 7,
   parameter logic [RAM_AW-1:0] DISP_BASE = 7'h60,
   parameter int COM_DIV = 11250
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               ram_rd,
   output logic [RAM_AW-1:0]  ram_addr,
   input  logic [COMMONS-1:0] ram_data,
   input  logic               bp,
   input  logic [COMMONS-1:0] l_reg,
   input  logic [COMMONS-1:0] y_reg,
   input  logic               blink,
   output logic [COMMONS-1:0] com,
   output logic [SEGS-1:0]    seg,
   output logic               bs,
   output logic               frame_start
);
   localparam int CW = $clog2(COM_DIV);
   localparam int KW = $clog2(COMMONS);
   localparam int IW = $clog2(SEGS);
   typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [KW-1:0] k, k_nx;
   logic [IW-1:0] idx, cap_idx;
   logic rd_q, shadow_valid, wrap, commit, bs_nx;
   logic [SEGS-1:0] shadow [COMMONS];
   logic [SEGS-1:0] active [COMMONS];
   assign wrap = cnt == CW'(COM_DIV - 1);
   assign k_nx = (k == KW'(COMMONS - 1)) ? '0 : k + KW'(1);
   assign commit = wrap && k_nx == '0 && shadow_valid;
   assign ram_rd = state == READ;
   assign ram_addr = DISP_BASE + RAM_AW'(idx);
`ifdef SM5_LCD_BLINK_EN
   assign bs_nx = l_reg[k_nx] & ~(y_reg[k_nx] & blink);
`else
   logic unused_blink;
   assign unused_blink = ^{y_reg, blink};
   assign bs_nx = l_reg[k_nx];
`endif
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (wrap ? READ : IDLE) :
                 state == READ ? (idx == IW'(SEGS - 1) ? WAIT : READ) :
                 state == WAIT ? DONE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         k <= '0;
         idx <= '0;
         cap_idx <= '0;
         rd_q <= 1'b0;
         shadow_valid <= 1'b0;
         com <= COMMONS'(1);
         seg <= '0;
         bs <= 1'b0;
         frame_start <= 1'b0;
         shadow <= '{default: '0};
         active <= '{default: '0};
      end else begin
         cnt <= wrap ? '0 : cnt + CW'(1);
         frame_start <= wrap && k_nx == '0;
         rd_q <= ram_rd;
         cap_idx <= idx;
         idx <= ram_rd ? idx + IW'(1) : '0;
         // Column written one clk after its address, matching RAM latency
         if (rd_q)
            for (int c = 0; c < COMMONS; c++) shadow[c][cap_idx] <= ram_data[c];
         if (commit) shadow_valid <= 1'b0;
         if (state == DONE) shadow_valid <= 1'b1;
         if (wrap) begin
            k <= k_nx;
            com <= COMMONS'(1) << k_nx;
            seg <= (commit ? shadow[k_nx] : active[k_nx]) & {SEGS{bp}};
            bs <= bs_nx;
            if (commit) active <= shadow;
         end
      end
   end
endmodule

// File: tb/tb_sm5_lcd_scan.sv
// tb_sm5_lcd_scan: table-driven scoreboard bench for sm5_lcd_scan (COMMONS=4, SEGS=32, COM_DIV=80).
module tb_sm5_lcd_scan;
   logic clk = 1'b0, rst_n = 1'b0;
   logic ram_rd, bp, blink, bs, frame_start;
   logic [6:0] ram_addr;
   logic [3:0] ram_data, l_reg, y_reg, com;
   logic [31:0] seg;
   logic [3:0] mem [128];
   int total = 0, pass = 0;
   typedef struct {logic bp; logic mix; logic [3:0] fill; logic [3:0] w60; logic [3:0] l; logic [3:0] y; logic blink;} vec_t;
   typedef struct {logic [3:0] com; logic [31:0] seg; logic bs;} exp_t;
   vec_t vt [6];
   exp_t q [$];
   sm5_lcd_scan #(.COMMONS(4), .SEGS(32), .RAM_AW(7), .DISP_BASE(7'h60), .COM_DIV(80)) dut (
      .clk(clk), .rst_n(rst_n), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
      .bp(bp), .l_reg(l_reg), .y_reg(y_reg), .blink(blink), .com(com), .seg(seg), .bs(bs),
      .frame_start(frame_start));
   always #5 clk = ~clk;
   always @(posedge clk) ram_data <= mem[ram_addr];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask
   task automatic wait_fs();
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = frame_start;
      end
      if (!seen) begin
         total++;
         $display("FAIL frame_start_timeout: got none expected pulse within 400 clks");
      end
   endtask
   function automatic logic [31:0] exp_seg(int c, logic b);
      logic [31:0] r;
      for (int s = 0; s < 32; s++) r[s] = mem[(96 + s) % 128][c] & b;
      return r;
   endfunction
   function automatic logic exp_bs(logic [3:0] l, logic [3:0] y, logic bl, int c);
`ifdef SM5_LCD_BLINK_EN
      return l[c] & ~(y[c] & bl);
`else
      return l[c];
`endif
   endfunction
   initial begin
      int n;
      bit found;
      exp_t e;
      vt[0] = '{1'b1, 1'b0, 4'h0, 4'h5, 4'hF, 4'h0, 1'b0};
      vt[1] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'hA, 4'h0, 1'b0};
      vt[2] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h5, 4'h0, 1'b0};
      vt[3] = '{1'b1, 1'b1, 4'h3, 4'h9, 4'hC, 4'h0, 1'b0};
      vt[4] = '{1'b1, 1'b1, 4'h7, 4'h6, 4'hF, 4'h2, 1'b1};
      vt[5] = '{1'b1, 1'b1, 4'h1, 4'h2, 4'hF, 4'h2, 1'b0};
      bp = 1'b1; l_reg = 4'h0; y_reg = 4'h0; blink = 1'b0;
      for (int a = 0; a < 128; a++) mem[a] = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_com", 32'(com), 32'h1);
      chk("rst_seg", seg, 32'h0);
      chk("rst_bs", 32'(bs), 32'h0);
      chk("rst_frame_start", 32'(frame_start), 32'h0);
      chk("rst_ram_rd", 32'(ram_rd), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h60);
      rst_n = 1'b1;
      for (int v = 0; v < 6; v++) begin
         for (int a = 0; a < 128; a++) mem[a] = vt[v].mix ? 4'(a * 5) ^ vt[v].fill : vt[v].fill;
         mem[96] = vt[v].w60;
         bp = vt[v].bp; l_reg = vt[v].l; y_reg = vt[v].y; blink = vt[v].blink;
         for (int c = 0; c < 4; c++) q.push_back('{4'(1 << c), exp_seg(c, vt[v].bp), exp_bs(vt[v].l, vt[v].y, vt[v].blink, c)});
         wait_fs();
         wait_fs();
         for (int c = 0; c < 4; c++) begin
            e = q.pop_front();
            chk($sformatf("v%0d_com%0d", v, c), 32'(com), 32'(e.com));
            chk($sformatf("v%0d_seg%0d", v, c), seg, e.seg);
            chk($sformatf("v%0d_bs%0d", v, c), 32'(bs), 32'(e.bs));
            if (c < 3) repeat (80) @(negedge clk);
         end
      end
      wait_fs();
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         n++;
         found = frame_start;
      end
      chk("frame_period", 32'(n), 32'd320);
      // Mid-frame RAM change must not tear the displayed frame
      for (int a = 0; a < 128; a++) mem[a] = 4'h0;
      mem[96] = 4'h5;
      bp = 1'b1;
      wait_fs();
      wait_fs();
      repeat (160) @(negedge clk);
      chk("tear_com4", 32'(com), 32'h4);
      mem[96] = 4'hA;
      repeat (80) @(negedge clk);
      chk("tear_old_com8", 32'(seg[0]), 32'h0);
      wait_fs();
      chk("tear_new_com1", 32'(seg[0]), 32'h0);
      repeat (80) @(negedge clk);
      chk("tear_new_com2", 32'(seg[0]), 32'h1);
      // Reset in the middle of a scan
      for (int a = 0; a < 128; a++) mem[a] = 4'hF;
      wait_fs();
      wait_fs();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = ram_rd && ram_addr == 7'h6A;
      end
      chk("midscan_found_i10", 32'(found), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midscan_ram_rd", 32'(ram_rd), 32'h0);
      chk("midscan_com", 32'(com), 32'h1);
      chk("midscan_seg", seg, 32'h0);
      rst_n = 1'b1;
      for (int a = 0; a < 128; a++) mem[a] = 4'(a * 3);
      wait_fs();
      chk("fresh_com1", seg, exp_seg(0, 1'b1));
      repeat (80) @(negedge clk);
      chk("fresh_com2", seg, exp_seg(1, 1'b1));
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
